riscv_exc_controller: RTL and testbench

- Exception/interrupt arbitration stage directly upstream of the CSR block.
- Collects external interrupt lines and synchronous exception flags from decode and the LSU, then selects one cause.
- Runs a request/acknowledge handshake with the core controller.
- On acknowledge, emits the one-cycle save strobes and cause code the CSR block uses to update mepc, mestatus, mstatus and mcause.

---
 rtl/riscv_defines.sv | 18 +
 rtl/riscv_irq_prio_enc.sv | 23 ++
 rtl/riscv_exc_controller.sv | 129 ++++++++++++
 tb/tb_riscv_exc_controller.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_defines.sv
// Shared definitions for the exception/interrupt controller: FSM state
// encoding and mcause codes (bit 5 flags an interrupt).
package riscv_defines;

  typedef enum logic [1:0] {
    EXC_IDLE,
    EXC_REQ,
    EXC_SAVE
  } exc_state_e;

  localparam logic [5:0] EXC_CAUSE_ILLEGAL_INSN = 6'h02;
  localparam logic [5:0] EXC_CAUSE_BREAKPOINT   = 6'h03;
  localparam logic [5:0] EXC_CAUSE_LOAD_FAULT   = 6'h05;
  localparam logic [5:0] EXC_CAUSE_STORE_FAULT  = 6'h07;
  localparam logic [5:0] EXC_CAUSE_ECALL_MMODE  = 6'h0B;
  localparam logic [5:0] EXC_CAUSE_IRQ_FLAG     = 6'h20;

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// Lowest-index-first priority encoder over up to 32 request lines.
module riscv_irq_prio_enc #(
  parameter int N = 32
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [4:0]   idx
);

  // Scanning downwards lets the lowest set index be the final assignment.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 5'(i);
      end
    end
  end

endmodule

// File: rtl/riscv_exc_controller.sv
// Exception/interrupt arbiter: selects one cause, handshakes with the core
// controller and issues the one-cycle CSR save strobes on acknowledge.
module riscv_exc_controller
  import riscv_defines::*;
#(
  parameter int N_IRQ = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic             irq_enable_i,
  input  logic             illegal_insn_i,
  input  logic             ebrk_insn_i,
  input  logic             ecall_insn_i,
  input  logic             lsu_load_err_i,
  input  logic             lsu_store_err_i,
  input  logic             exc_ack_i,
  input  logic             exc_kill_i,
  output logic             exc_req_o,
  output logic             exc_save_if_o,
  output logic             exc_save_id_o,
  output logic             save_exc_cause_o,
  output logic [5:0]       exc_cause_o,
  output logic [N_IRQ-1:0] irq_pending_o
);

  exc_state_e       state_q, state_d;
  logic [5:0]       cause_q, cause_d;
  logic             is_irq_q, is_irq_d;
  logic [N_IRQ-1:0] irq_q, pending_q, pending_d;
  logic [N_IRQ-1:0] irq_rise, irq_cand, clr_mask;
  logic             irq_valid;
  logic [4:0]       irq_idx;
  logic             sel_valid, sel_irq;
  logic [5:0]       sel_cause;

  // An edge arriving this cycle is eligible immediately, not one cycle later.
  always_comb begin
    irq_rise = irq_i & ~irq_q;
    irq_cand = irq_enable_i ? (pending_q | irq_rise) : '0;
  end

  riscv_irq_prio_enc #(
    .N(N_IRQ)
  ) u_prio_enc (
    .req  (irq_cand),
    .valid(irq_valid),
    .idx  (irq_idx)
  );

  always_comb begin
    sel_valid = 1'b1;
    sel_irq   = 1'b0;
    sel_cause = '0;
    if (lsu_load_err_i)       sel_cause = EXC_CAUSE_LOAD_FAULT;
    else if (lsu_store_err_i) sel_cause = EXC_CAUSE_STORE_FAULT;
    else if (illegal_insn_i)  sel_cause = EXC_CAUSE_ILLEGAL_INSN;
    else if (ebrk_insn_i)     sel_cause = EXC_CAUSE_BREAKPOINT;
    else if (ecall_insn_i)    sel_cause = EXC_CAUSE_ECALL_MMODE;
    else if (irq_valid) begin
      sel_irq   = 1'b1;
      sel_cause = EXC_CAUSE_IRQ_FLAG | {1'b0, irq_idx};
    end else begin
      sel_valid = 1'b0;
    end
  end

  // A new edge on the bit being cleared in SAVE keeps it pending.
  always_comb begin
    for (int i = 0; i < N_IRQ; i++) begin
      clr_mask[i] = (state_q == EXC_SAVE) && is_irq_q && (cause_q[4:0] == 5'(i));
    end
    pending_d = (pending_q & ~clr_mask) | irq_rise;
  end

  always_comb begin
    state_d          = state_q;
    cause_d          = cause_q;
    is_irq_d         = is_irq_q;
    exc_req_o        = 1'b0;
    save_exc_cause_o = 1'b0;
    exc_save_if_o    = 1'b0;
    exc_save_id_o    = 1'b0;
    exc_cause_o      = (state_q != EXC_IDLE) ? cause_q : '0;
    unique case (state_q)
      EXC_IDLE: begin
        if (sel_valid) begin
          state_d  = EXC_REQ;
          cause_d  = sel_cause;
          is_irq_d = sel_irq;
        end
      end
      EXC_REQ: begin
        exc_req_o = 1'b1;
        if (exc_kill_i)                      state_d = EXC_IDLE;
        else if (is_irq_q && !irq_enable_i)  state_d = EXC_IDLE;
        else if (exc_ack_i)                  state_d = EXC_SAVE;
      end
      EXC_SAVE: begin
        save_exc_cause_o = 1'b1;
        exc_save_if_o    = is_irq_q;
        exc_save_id_o    = ~is_irq_q;
        state_d          = EXC_IDLE;
      end
      default: state_d = EXC_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EXC_IDLE;
      cause_q   <= '0;
      is_irq_q  <= 1'b0;
      irq_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      is_irq_q  <= is_irq_d;
      irq_q     <= irq_i;
      pending_q <= pending_d;
    end
  end

  assign irq_pending_o = pending_q;

endmodule

// File: tb/tb_riscv_exc_controller.sv
// Directed bench: stimulus pushes expected request/save events into a queue,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_riscv_exc_controller;

  localparam int N_IRQ = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_IRQ-1:0] irq_i;
  logic             irq_enable_i, illegal_insn_i, ebrk_insn_i, ecall_insn_i;
  logic             lsu_load_err_i, lsu_store_err_i, exc_ack_i, exc_kill_i;
  logic             exc_req_o, exc_save_if_o, exc_save_id_o, save_exc_cause_o;
  logic [5:0]       exc_cause_o;
  logic [N_IRQ-1:0] irq_pending_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         is_save;
    logic [5:0] cause;
    bit         save_if;
    bit         save_id;
  } exp_t;

  exp_t exp_q[$];

  riscv_exc_controller #(.N_IRQ(N_IRQ)) dut (
    .clk             (clk),
    .rst             (rst),
    .irq_i           (irq_i),
    .irq_enable_i    (irq_enable_i),
    .illegal_insn_i  (illegal_insn_i),
    .ebrk_insn_i     (ebrk_insn_i),
    .ecall_insn_i    (ecall_insn_i),
    .lsu_load_err_i  (lsu_load_err_i),
    .lsu_store_err_i (lsu_store_err_i),
    .exc_ack_i       (exc_ack_i),
    .exc_kill_i      (exc_kill_i),
    .exc_req_o       (exc_req_o),
    .exc_save_if_o   (exc_save_if_o),
    .exc_save_id_o   (exc_save_id_o),
    .save_exc_cause_o(save_exc_cause_o),
    .exc_cause_o     (exc_cause_o),
    .irq_pending_o   (irq_pending_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input bit is_save, input logic [5:0] cause, input bit sif, input bit sid);
    exp_t e;
    e.is_save = is_save;
    e.cause   = cause;
    e.save_if = sif;
    e.save_id = sid;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a new request (rising exc_req_o) or a save cycle consumes one entry.
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (exc_req_o && !prev_req) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_req: got cause %0h expected no request", exc_cause_o);
      end else begin
        e = exp_q.pop_front();
        check("req_event_kind", 32'(e.is_save), 32'(0));
        check("req_cause", 32'(exc_cause_o), 32'(e.cause));
      end
    end
    if (save_exc_cause_o) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_save: got cause %0h expected no save", exc_cause_o);
      end else begin
        e = exp_q.pop_front();
        check("save_event_kind", 32'(e.is_save), 32'(1));
        check("save_cause", 32'(exc_cause_o), 32'(e.cause));
        check("save_if", 32'(exc_save_if_o), 32'(e.save_if));
        check("save_id", 32'(exc_save_id_o), 32'(e.save_id));
      end
    end else if (exc_save_if_o || exc_save_id_o) begin
      total++; bad++;
      $display("FAIL stray_strobe: got if=%0b id=%0b expected 0", exc_save_if_o, exc_save_id_o);
    end
    prev_req = exc_req_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; irq_i = '0; irq_enable_i = 1'b0;
    illegal_insn_i = 1'b0; ebrk_insn_i = 1'b0; ecall_insn_i = 1'b0;
    lsu_load_err_i = 1'b0; lsu_store_err_i = 1'b0;
    exc_ack_i = 1'b0; exc_kill_i = 1'b0;
    tick(); tick();
    check("rst_req", 32'(exc_req_o), 32'(0));
    check("rst_cause", 32'(exc_cause_o), 32'(0));
    check("rst_save", 32'(save_exc_cause_o), 32'(0));
    check("rst_pending", irq_pending_o, 32'(0));
    rst = 1'b0;
    tick();

    // IRQ 3 rising edge, ack, save with pc_if.
    irq_enable_i = 1'b1; irq_i = 32'h8; push(0, 6'h23, 0, 0);
    tick();
    check("t1_req", 32'(exc_req_o), 32'(1));
    check("t1_cause", 32'(exc_cause_o), 32'h23);
    exc_ack_i = 1'b1; push(1, 6'h23, 1, 0);
    tick();
    exc_ack_i = 1'b0;
    check("t1_save", 32'(save_exc_cause_o), 32'(1));
    check("t1_save_if", 32'(exc_save_if_o), 32'(1));
    tick();
    check("t1_pend3_clr", 32'(irq_pending_o[3]), 32'(0));
    check("t1_idle_req", 32'(exc_req_o), 32'(0));
    check("t1_idle_cause", 32'(exc_cause_o), 32'(0));

    // Illegal beats a pending IRQ 0; IRQ 0 follows after SAVE.
    irq_i = 32'h1; illegal_insn_i = 1'b1; push(0, 6'h02, 0, 0);
    tick();
    check("t2_cause", 32'(exc_cause_o), 32'h02);
    exc_ack_i = 1'b1; push(1, 6'h02, 0, 1);
    tick();
    illegal_insn_i = 1'b0; exc_ack_i = 1'b0;
    check("t2_save_id", 32'(exc_save_id_o), 32'(1));
    push(0, 6'h20, 0, 0);
    tick();
    check("t2_idle_req", 32'(exc_req_o), 32'(0));
    check("t2_pend0", 32'(irq_pending_o[0]), 32'(1));
    tick();
    check("t2_irq0_req", 32'(exc_req_o), 32'(1));
    exc_ack_i = 1'b1; push(1, 6'h20, 1, 0);
    tick();
    exc_ack_i = 1'b0;
    tick();
    irq_i = '0;

    // Load + store together, then ecall alone.
    lsu_load_err_i = 1'b1; lsu_store_err_i = 1'b1; push(0, 6'h05, 0, 0);
    tick();
    check("t3_cause_ld", 32'(exc_cause_o), 32'h05);
    exc_ack_i = 1'b1; push(1, 6'h05, 0, 1);
    tick();
    lsu_load_err_i = 1'b0; lsu_store_err_i = 1'b0; exc_ack_i = 1'b0;
    tick();
    ecall_insn_i = 1'b1; push(0, 6'h0B, 0, 0);
    tick();
    exc_ack_i = 1'b1; push(1, 6'h0B, 0, 1);
    tick();
    ecall_insn_i = 1'b0; exc_ack_i = 1'b0;
    check("t3_ecall_id", 32'(exc_save_id_o), 32'(1));
    tick();
    check("t3_ecall_id_1cyc", 32'(exc_save_id_o), 32'(0));
    check("t3_save_1cyc", 32'(save_exc_cause_o), 32'(0));

    // Kill during REQ keeps IRQ 7 pending and it is re-requested.
    irq_i = 32'h80; push(0, 6'h27, 0, 0);
    tick();
    check("t4_pend7", 32'(irq_pending_o[7]), 32'(1));
    exc_kill_i = 1'b1; exc_ack_i = 1'b1;
    tick();
    exc_kill_i = 1'b0; exc_ack_i = 1'b0;
    check("t4_kill_req", 32'(exc_req_o), 32'(0));
    check("t4_kill_save", 32'(save_exc_cause_o), 32'(0));
    check("t4_kill_pend7", 32'(irq_pending_o[7]), 32'(1));
    push(0, 6'h27, 0, 0);
    tick();
    check("t4_rereq", 32'(exc_req_o), 32'(1));
    exc_ack_i = 1'b1; push(1, 6'h27, 1, 0);
    tick();
    exc_ack_i = 1'b0;
    tick();
    check("t4_pend7_clr", 32'(irq_pending_o[7]), 32'(0));
    irq_i = '0;

    // Enable drop aborts IRQ 1; re-enable re-requests; ebreak ignores enable.
    irq_i = 32'h2; push(0, 6'h21, 0, 0);
    tick();
    irq_enable_i = 1'b0;
    tick();
    check("t5_abort_req", 32'(exc_req_o), 32'(0));
    check("t5_abort_pend1", 32'(irq_pending_o[1]), 32'(1));
    tick();
    check("t5_disabled_req", 32'(exc_req_o), 32'(0));
    irq_enable_i = 1'b1; push(0, 6'h21, 0, 0);
    tick();
    check("t5_reen_cause", 32'(exc_cause_o), 32'h21);
    exc_ack_i = 1'b1; push(1, 6'h21, 1, 0);
    tick();
    exc_ack_i = 1'b0;
    tick();
    irq_i = '0; irq_enable_i = 1'b0; ebrk_insn_i = 1'b1; push(0, 6'h03, 0, 0);
    tick();
    check("t5_ebrk_cause", 32'(exc_cause_o), 32'h03);
    exc_ack_i = 1'b1; push(1, 6'h03, 0, 1);
    tick();
    ebrk_insn_i = 1'b0; exc_ack_i = 1'b0;
    tick();
    irq_enable_i = 1'b1;

    // Reset during REQ, then IRQ 2 re-edge during its own SAVE.
    irq_i = 32'h10; push(0, 6'h24, 0, 0);
    tick();
    check("t6_req", 32'(exc_req_o), 32'(1));
    rst = 1'b1; irq_i = '0; exc_ack_i = 1'b1;
    tick();
    rst = 1'b0; exc_ack_i = 1'b0;
    check("t6_rst_req", 32'(exc_req_o), 32'(0));
    check("t6_rst_save", 32'(save_exc_cause_o), 32'(0));
    check("t6_rst_cause", 32'(exc_cause_o), 32'(0));
    check("t6_rst_pending", irq_pending_o, 32'(0));
    irq_i = 32'h4; push(0, 6'h22, 0, 0);
    tick();
    check("t6_irq2_cause", 32'(exc_cause_o), 32'h22);
    irq_i = '0; exc_ack_i = 1'b1; push(1, 6'h22, 1, 0);
    tick();
    exc_ack_i = 1'b0; irq_i = 32'h4; push(0, 6'h22, 0, 0);
    tick();
    check("t6_set_wins", 32'(irq_pending_o[2]), 32'(1));
    check("t6_idle_req", 32'(exc_req_o), 32'(0));
    tick();
    check("t6_rereq", 32'(exc_req_o), 32'(1));
    exc_ack_i = 1'b1; push(1, 6'h22, 1, 0);
    tick();
    exc_ack_i = 1'b0;
    tick();
    irq_i = '0;
    tick(); tick();

    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
